// File: rtl/uart_fifo_gen_if.sv
// Handshake/status bundle between the UART FIFO and its producer/consumer.
// The initiator drives requests and configuration; the FIFO returns head data and status.
interface uart_fifo_gen_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ERR_W  = 3,
   parameter int unsigned CNT_W  = 5
);
   localparam int unsigned EW = (ERR_W > 0) ? ERR_W : 1;

   logic              clr;
   logic              en;
   logic              push_in;
   logic [DATA_W-1:0] din;
   logic [EW-1:0]     err_in;
   logic              pop_in;
   logic [DATA_W-1:0] dout;
   logic [EW-1:0]     err_out;
   logic [CNT_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              overrun;
   logic              underrun;
   logic [CNT_W-1:0]  threshold;
   logic              thre_trigger;
   logic              err_in_fifo;

   modport master (
      output clr, en, push_in, din, err_in, pop_in, threshold,
      input  dout, err_out, count, empty, full, overrun, underrun,
             thre_trigger, err_in_fifo
   );

   modport slave (
      input  clr, en, push_in, din, err_in, pop_in, threshold,
      output dout, err_out, count, empty, full, overrun, underrun,
             thre_trigger, err_in_fifo
   );
endinterface

// File: rtl/uart_fifo_gen.sv
// First-word-fall-through circular FIFO for the 16550 TX/RX paths, with per-entry
// error tags, occupancy count, synchronous flush and a depth-1 16450 mode.
module uart_fifo_gen #(
   parameter  int unsigned DATA_W = 8,
   parameter  int unsigned DEPTH  = 16,
   parameter  int unsigned ERR_W  = 3,
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               rst,
   uart_fifo_gen_if.slave     bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = (ERR_W > 0) ? ERR_W : 1;

   logic [DATA_W-1:0] data_mem_q [DEPTH];
   logic [EW-1:0]     tag_mem_q  [DEPTH];

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] errcnt_q, errcnt_d;
   logic             empty_q, empty_d;
   logic             full_q, full_d;
   logic             overrun_q, overrun_d;
   logic             underrun_q, underrun_d;
   logic             en_q;

   logic             flush;
   logic             push_acc;
   logic             pop_acc;
   logic [CNT_W-1:0] depth_eff;
   logic [EW-1:0]    tag_in;
   logic [EW-1:0]    tag_head;

   // With no tag storage the tag path is forced to zero so err_in_fifo never sets.
   assign tag_in   = (ERR_W > 0) ? bus.err_in : '0;
   assign tag_head = (ERR_W > 0) ? tag_mem_q[rptr_q] : '0;

   assign depth_eff = bus.en ? CNT_W'(DEPTH) : CNT_W'(1);
   assign flush     = bus.clr | (bus.en != en_q);
   assign push_acc  = bus.push_in & (~full_q | bus.pop_in);
   assign pop_acc   = bus.pop_in & ~empty_q;

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      errcnt_d   = errcnt_q;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
      empty_d    = empty_q;
      full_d     = full_q;

      if (flush) begin
         wptr_d   = '0;
         rptr_d   = '0;
         count_d  = '0;
         errcnt_d = '0;
         empty_d  = 1'b1;
         full_d   = 1'b0;
      end else begin
         if (push_acc) wptr_d = wptr_q + PW'(1);
         if (pop_acc)  rptr_d = rptr_q + PW'(1);

         case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase

         case ({push_acc & (|tag_in), pop_acc & (|tag_head)})
            2'b10:   errcnt_d = errcnt_q + CNT_W'(1);
            2'b01:   errcnt_d = errcnt_q - CNT_W'(1);
            default: errcnt_d = errcnt_q;
         endcase

         overrun_d  = bus.push_in & full_q & ~bus.pop_in;
         underrun_d = bus.pop_in & empty_q;
         // Flags come from the next count so count/empty/full move on the same edge.
         empty_d    = (count_d == '0);
         full_d     = (count_d == depth_eff);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         errcnt_q   <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
         en_q       <= 1'b1;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         errcnt_q   <= errcnt_d;
         empty_q    <= empty_d;
         full_q     <= full_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
         en_q       <= bus.en;
      end
   end

   // Storage is never reset; contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (push_acc && !flush) begin
         data_mem_q[wptr_q] <= bus.din;
         tag_mem_q[wptr_q]  <= tag_in;
      end
   end

   assign bus.dout         = data_mem_q[rptr_q];
   assign bus.err_out      = tag_head;
   assign bus.count        = count_q;
   assign bus.empty        = empty_q;
   assign bus.full         = full_q;
   assign bus.overrun      = overrun_q;
   assign bus.underrun     = underrun_q;
   assign bus.thre_trigger = (count_q >= bus.threshold);
   assign bus.err_in_fifo  = (errcnt_q != '0);

endmodule

// File: tb/tb_uart_fifo_gen.sv
// Directed plus randomized bench for uart_fifo_gen against a queue-based reference model.
module tb_uart_fifo_gen;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ERR_W  = 3;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

   typedef struct {
      logic [DATA_W-1:0] d;
      logic [ERR_W-1:0]  e;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_fifo_gen_if #(.DATA_W(DATA_W), .ERR_W(ERR_W), .CNT_W(CNT_W)) bus ();

   uart_fifo_gen #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_W(ERR_W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned passed = 0;
   int unsigned total  = 0;

   ent_t q[$];
   logic m_ov     = 1'b0;
   logic m_un     = 1'b0;
   logic m_prev_en = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_err_any();
      foreach (q[i]) if (q[i].e != '0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_all(input string ctx);
      chk({ctx, ":count"}, 32'(bus.count), 32'(q.size()));
      chk({ctx, ":empty"}, 32'(bus.empty), 32'(q.size() == 0));
      chk({ctx, ":full"}, 32'(bus.full), 32'(q.size() == (m_prev_en ? DEPTH : 1)));
      chk({ctx, ":overrun"}, 32'(bus.overrun), 32'(m_ov));
      chk({ctx, ":underrun"}, 32'(bus.underrun), 32'(m_un));
      chk({ctx, ":thre"}, 32'(bus.thre_trigger), 32'(q.size() >= int'(bus.threshold)));
      chk({ctx, ":errfifo"}, 32'(bus.err_in_fifo), 32'(model_err_any()));
      if (q.size() != 0) begin
         chk({ctx, ":dout"}, 32'(bus.dout), 32'(q[0].d));
         chk({ctx, ":errout"}, 32'(bus.err_out), 32'(q[0].e));
      end
   endtask

   // One clock: drive at negedge, advance the model from pre-edge state, check after the edge.
   task automatic step(input logic p, input logic [DATA_W-1:0] d, input logic [ERR_W-1:0] e,
                       input logic po, input logic c, input logic en_v, input string ctx);
      int unsigned depth;
      logic was_full, was_empty, push_ok, pop_ok;
      ent_t ent;
      @(negedge clk);
      bus.push_in = p;
      bus.din     = d;
      bus.err_in  = e;
      bus.pop_in  = po;
      bus.clr     = c;
      bus.en      = en_v;
      depth     = m_prev_en ? DEPTH : 1;
      was_full  = (q.size() == depth);
      was_empty = (q.size() == 0);
      if (c || (en_v != m_prev_en)) begin
         q.delete();
         m_ov = 1'b0;
         m_un = 1'b0;
      end else begin
         push_ok = p && (!was_full || po);
         pop_ok  = po && !was_empty;
         m_ov = p && was_full && !po;
         m_un = po && was_empty;
         if (pop_ok) void'(q.pop_front());
         if (push_ok) begin
            ent.d = d;
            ent.e = e;
            q.push_back(ent);
         end
      end
      m_prev_en = en_v;
      @(posedge clk);
      #1;
      check_all(ctx);
   endtask

   initial begin
      bus.push_in   = 1'b0;
      bus.din       = '0;
      bus.err_in    = '0;
      bus.pop_in    = 1'b0;
      bus.clr       = 1'b0;
      bus.en        = 1'b1;
      bus.threshold = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all("reset");

      bus.threshold = CNT_W'(8);
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h11 + i), '0, 1'b0, 1'b0, 1'b1, "fill");
      step(1'b1, 8'hEE, '0, 1'b0, 1'b0, 1'b1, "overrun");
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "ov_idle");
      for (int i = 0; i < 16; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "drain");
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "underrun");
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "un_idle");

      for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h30 + i), '0, 1'b0, 1'b0, 1'b1, "wrap_push1");
      for (int i = 0; i < 8; i++)  step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "wrap_pop");
      for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h50 + i), '0, 1'b0, 1'b0, 1'b1, "wrap_push2");
      for (int i = 0; i < 14; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "wrap_drain");

      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h70 + i), '0, 1'b0, 1'b0, 1'b1, "sim_fill");
      step(1'b1, 8'hA5, '0, 1'b1, 1'b0, 1'b1, "pushpop_full");
      step(1'b1, 8'hA6, '0, 1'b0, 1'b1, 1'b1, "clr_vs_push");
      step(1'b1, 8'hA7, '0, 1'b1, 1'b0, 1'b1, "pushpop_empty");
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "pp_drain");

      bus.threshold = '0;
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "thre0");

      bus.threshold = CNT_W'(8);
      step(1'b1, 8'h01, 3'b000, 1'b0, 1'b0, 1'b1, "tag1");
      step(1'b1, 8'h02, 3'b000, 1'b0, 1'b0, 1'b1, "tag2");
      step(1'b1, 8'h03, 3'b010, 1'b0, 1'b0, 1'b1, "tag3");
      step(1'b1, 8'h04, 3'b000, 1'b0, 1'b0, 1'b1, "tag4");
      for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, "tag_drain");

      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), '0, 1'b0, 1'b0, 1'b1, "en_fill");
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "en_off_flush");
      step(1'b1, 8'hC1, 3'b001, 1'b0, 1'b0, 1'b0, "m16450_push");
      step(1'b1, 8'hC2, '0, 1'b0, 1'b0, 1'b0, "m16450_ovr");
      step(1'b1, 8'hC3, '0, 1'b1, 1'b0, 1'b0, "m16450_pp");
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "en_on_flush");

      for (int i = 0; i < 600; i++) begin
         logic en_r;
         en_r = ($urandom_range(0, 99) < 3) ? ~m_prev_en : m_prev_en;
         if ($urandom_range(0, 49) == 0) bus.threshold = CNT_W'($urandom_range(0, 17));
         step(($urandom_range(0, 99) < 55), 8'($urandom), 3'($urandom_range(0, 3) == 0 ? $urandom : 0),
              ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 2), en_r, "rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
